// File: rtl/dig_tick_event_counter.sv
// dig_tick_event_counter
// Brings a slow, free-running level into the clk domain, turns each detected
// edge into a one-cycle tick and counts the ticks in a wrapping, clearable
// counter that pulses ovf on every wrap.
// Build option: define DIG_TICK_BOTH_EDGES_EN so that both rising and falling
// edges produce a tick. By default only rising edges do.
module dig_tick_event_counter #(
  parameter int unsigned Bits       = 8,
  parameter int unsigned maxValue   = 255,
  parameter int unsigned SyncStages = 2
) (
  input  logic            PORT_C,
  input  logic            PORT_nRst,
  input  logic            PORT_in,
  input  logic            PORT_en,
  input  logic            PORT_clr,
  output logic            PORT_tick,
  output logic [Bits-1:0] PORT_out,
  output logic            PORT_ovf
);

  localparam logic [Bits-1:0] MAX_COUNT = Bits'(maxValue);
  localparam logic [Bits-1:0] ONE       = Bits'(1);

  logic [SyncStages-1:0] sync_q;
  logic                  hist_q;
  logic                  sync_last;
  logic                  edge_det;
  logic                  at_max;

  assign sync_last = sync_q[SyncStages-1];

  // Synchroniser chain for the asynchronous input level.
  always_ff @(posedge PORT_C or negedge PORT_nRst) begin
    if (!PORT_nRst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], PORT_in};
    end
  end

  // History flop: the synchronised level one cycle ago. Clearing it to 0
  // means a level that is already high at reset release is counted once.
  always_ff @(posedge PORT_C or negedge PORT_nRst) begin
    if (!PORT_nRst) begin
      hist_q <= 1'b0;
    end else begin
      hist_q <= sync_last;
    end
  end

`ifdef DIG_TICK_BOTH_EDGES_EN
  assign edge_det = sync_last ^ hist_q;
`else
  assign edge_det = sync_last & ~hist_q;
`endif

  assign at_max = (PORT_out == MAX_COUNT);

  // Tick is a registered copy of the edge, independent of enable and clear.
  always_ff @(posedge PORT_C or negedge PORT_nRst) begin
    if (!PORT_nRst) begin
      PORT_tick <= 1'b0;
    end else begin
      PORT_tick <= edge_det;
    end
  end

  // Event counter: clear wins, then wrap at the terminal count, then increment.
  always_ff @(posedge PORT_C or negedge PORT_nRst) begin
    if (!PORT_nRst) begin
      PORT_out <= '0;
      PORT_ovf <= 1'b0;
    end else if (PORT_clr) begin
      PORT_out <= '0;
      PORT_ovf <= 1'b0;
    end else if (edge_det && PORT_en) begin
      if (at_max) begin
        PORT_out <= '0;
        PORT_ovf <= 1'b1;
      end else begin
        PORT_out <= PORT_out + ONE;
        PORT_ovf <= 1'b0;
      end
    end else begin
      PORT_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dig_tick_event_counter.sv
// Testbench for dig_tick_event_counter (Bits=4, maxValue=9, SyncStages=2).
// Driver pushes the expected post-edge outputs into a scoreboard queue; a
// monitor pops one entry after every rising clock edge and compares.
module tb_dig_tick_event_counter;
  localparam int BITS = 4;
  localparam int MAXV = 9;
  localparam int SS   = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            din;
  logic            en;
  logic            clr;
  logic            tick;
  logic [BITS-1:0] out;
  logic            ovf;

  always #5 clk = ~clk;

  dig_tick_event_counter #(
    .Bits(BITS), .maxValue(MAXV), .SyncStages(SS)
  ) dut (
    .PORT_C(clk), .PORT_nRst(rst_n), .PORT_in(din), .PORT_en(en),
    .PORT_clr(clr), .PORT_tick(tick), .PORT_out(out), .PORT_ovf(ovf)
  );

  typedef struct packed {
    logic            tick;
    logic [BITS-1:0] out;
    logic            ovf;
  } exp_t;

  exp_t sb[$];
  bit   lvl[$];      // input level seen at each clock edge (0 while in reset)
  int   cnt;
  int   checks = 0;
  int   errors = 0;

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < lvl.size(); i++) lvl[i] = 1'b0;
    cnt = 0;
  endtask

  // Drive one cycle of inputs and queue what the outputs must be after the
  // next rising edge. An input change at edge m shows up as a tick at edge m+SS.
  task automatic step(logic v_in, logic v_en, logic v_clr, logic v_rst_n);
    exp_t e;
    bit   s, h, ev;
    @(negedge clk);
    din   = v_in;
    en    = v_en;
    clr   = v_clr;
    rst_n = v_rst_n;
    if (!v_rst_n) begin
      lvl.push_back(1'b0);
      model_reset();
      e = '0;
    end else begin
      lvl.push_back(v_in);
      s = lvl[lvl.size()-1-SS];
      h = lvl[lvl.size()-2-SS];
`ifdef DIG_TICK_BOTH_EDGES_EN
      ev = s != h;
`else
      ev = s && !h;
`endif
      e.tick = ev;
      e.ovf  = 1'b0;
      if (v_clr) cnt = 0;
      else if (ev && v_en) begin
        if (cnt == MAXV) begin
          cnt   = 0;
          e.ovf = 1'b1;
        end else cnt = cnt + 1;
      end
      e.out = cnt[BITS-1:0];
    end
    while (lvl.size() > 16) void'(lvl.pop_front());
    sb.push_back(e);
  endtask

  task automatic pulses(int n, int hi, int lo, logic v_en);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < hi; i++) step(1'b1, v_en, 1'b0, 1'b1);
      for (int i = 0; i < lo; i++) step(1'b0, v_en, 1'b0, 1'b1);
    end
  endtask

  // Monitor: compare DUT outputs against the scoreboard after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("tick", int'(tick), int'(e.tick));
        check("out",  int'(out),  int'(e.out));
        check("ovf",  int'(ovf),  int'(e.ovf));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    din   = 1'b0;
    en    = 1'b1;
    clr   = 1'b0;
    cnt   = 0;
    for (int i = 0; i < SS + 2; i++) lvl.push_back(1'b0);
    #2;
    check("reset_tick", int'(tick), 0);
    check("reset_out",  int'(out),  0);
    check("reset_ovf",  int'(ovf),  0);

    // Reset held while the input toggles, then release with input low.
    for (int i = 0; i < 6; i++) step(logic'(i % 2 == 0), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 1'b1);

    // Single rising edge for latency, then wrap: 10 edges spaced 8 cycles.
    pulses(1, 4, 6, 1'b1);
    pulses(9, 4, 4, 1'b1);

    // Enable low: ticks only.
    pulses(3, 4, 4, 1'b0);

    // Count to five, then clear coincident with a tick.
    pulses(5, 4, 4, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b1);

    // Run up a count, then assert reset between edges.
    pulses(7, 3, 3, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_tick", int'(tick), 0);
    check("async_out",  int'(out),  0);
    check("async_ovf",  int'(ovf),  0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #2;
    check("release_high_count", int'(out), 1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1);

    // Randomised phase: input level, enable and occasional clear.
    for (int i = 0; i < 400; i++) begin
      step(logic'($urandom_range(0, 2) == 0 ? ~din : din),
           logic'($urandom_range(0, 3) != 0),
           logic'($urandom_range(0, 15) == 0),
           1'b1);
    end
    for (int i = 0; i < 6; i++) step(din, 1'b1, 1'b0, 1'b1);

    @(posedge clk);
    #2;
    check("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
